// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and access sequencer sharing one 4K-word data memory port.
// Optional feature macro DM_ARB_LOCK_EN adds m1_lock for atomic port-1 bursts.
module dm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
`ifdef DM_ARB_LOCK_EN
    input  logic                m1_lock,
`endif
    output logic                m0_done,
    output logic                m1_done,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  prio;
    logic                  win;
    logic                  cmd_we;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_be;

    logic                  grant_valid;
    logic                  grant_id;
    logic                  lock_eff;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [DATA_W/8-1:0]   sel_be;

`ifdef DM_ARB_LOCK_EN
    logic lock_held;
    assign lock_eff = lock_held && m1_lock;
`else
    assign lock_eff = 1'b0;
`endif

    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            IDLE: begin
                if (lock_eff) begin
                    // While locked, port 0 is ignored even if it is requesting
                    grant_valid = m1_req;
                    grant_id    = 1'b1;
                end else if (m0_req && m1_req) begin
                    grant_valid = 1'b1;
                    grant_id    = prio;
                end else if (m0_req) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (m1_req) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                if (grant_valid) begin
                    next_state = BUSY;
                end
            end
            BUSY:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign sel_we    = grant_id ? m1_we    : m0_we;
    assign sel_addr  = grant_id ? m1_addr  : m0_addr;
    assign sel_wdata = grant_id ? m1_wdata : m0_wdata;
    assign sel_be    = grant_id ? m1_be    : m0_be;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            win       <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_be    <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state <= next_state;
            if (grant_valid) begin
                win       <= grant_id;
                cmd_we    <= sel_we;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
                cmd_be    <= sel_be;
                if (!lock_eff) begin
                    prio <= ~grant_id;
                end
            end
            if (state == BUSY && !cmd_we) begin
                if (win) begin
                    m1_rdata <= mem_rdata;
                end else begin
                    m0_rdata <= mem_rdata;
                end
            end
        end
    end

`ifdef DM_ARB_LOCK_EN
    // The lock is armed by a locked port-1 grant and released once m1_lock is seen low in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_held <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_valid) begin
                lock_held <= grant_id && m1_lock;
            end else if (!m1_lock) begin
                lock_held <= 1'b0;
            end
        end
    end
`endif

    // Memory strobes decode straight from state so an async reset drops them at once
    assign mem_write = (state == BUSY) &&  cmd_we;
    assign mem_read  = (state == BUSY) && !cmd_we;
    assign mem_a     = (state == BUSY) ? cmd_addr  : '0;
    assign mem_wdata = (state == BUSY) ? cmd_wdata : '0;
    assign mem_be    = (state == BUSY) ? cmd_be    : '0;

    assign m0_done = (state == RESP) && !win;
    assign m1_done = (state == RESP) &&  win;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural 4K-word memory.
// Define DM_ARB_LOCK_EN to also exercise the m1_lock burst path.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m1_lock;
    logic        m0_done, m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic [11:0] mem_a;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem_model [0:4095];

    typedef struct {
        bit          port;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    int          done_cycles[$];
    logic [31:0] exp_rdata [2];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    bit          pend = 0;

    dm_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
`ifdef DM_ARB_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m0_done(m0_done), .m1_done(m1_done), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    assign mem_rdata = mem_model[mem_a];

    // Behavioural memory commits byte-enabled writes on the edge that ends BUSY
    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_model[mem_a][b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic expect_txn(input bit port, input bit we, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rdata);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    // Holds one request until its done pulse, then drops req in the following IDLE cycle
    task automatic apply_stimulus(input bit port, input bit we, input logic [11:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be, input bit lock);
        int  waited = 0;
        bit  seen = 0;
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_lock = lock;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end
        while (!seen && waited < 60) begin
            @(negedge clk);
            waited++;
            seen = port ? m1_done : m0_done;
        end
        if (!seen) check_output(port ? "m1_done_timeout" : "m0_done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (port) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    // Scoreboard monitor: pops the expected transaction whenever a done pulse appears
    always @(negedge clk) begin
        txn_t e;
        bit   had_access;
        if (!reset) begin
            pend = 0;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
        end else begin
            had_access = pend;
            pend = mem_read || mem_write;
            if (mem_read || mem_write) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_access", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    check_output("mem_write", 32'(mem_write), 32'(e.we));
                    check_output("mem_read", 32'(mem_read), 32'(!e.we));
                    check_output("mem_a", 32'(mem_a), 32'(e.addr));
                    check_output("mem_wdata", mem_wdata, e.wdata);
                    check_output("mem_be", 32'(mem_be), 32'(e.be));
                end
            end else begin
                check_output("idle_mem_zero", {16'(mem_a), 12'(mem_wdata != 0), mem_be}, 32'd0);
            end
            if (m0_done || m1_done) begin
                done_cycles.push_back(cycle);
                check_output("done_both", 32'(m0_done && m1_done), 32'd0);
                check_output("done_latency", 32'(had_access), 32'd1);
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("grant_port", 32'(m1_done), 32'(e.port));
                    if (!e.we) exp_rdata[e.port] = e.rdata;
                    check_output("m0_rdata", m0_rdata, exp_rdata[0]);
                    check_output("m1_rdata", m1_rdata, exp_rdata[1]);
                end
            end else if (had_access) begin
                check_output("done_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = '0;
        mem_model[12'h030] = 32'h0BADF00D;
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_lock = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check_output("rst_done", {30'd0, m0_done, m1_done}, 32'd0);
        check_output("rst_m0_rdata", m0_rdata, 32'd0);
        check_output("rst_m1_rdata", m1_rdata, 32'd0);
        check_output("rst_mem_a", 32'(mem_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] single write from port 0");
        @(posedge clk);
        #1;
        expect_txn(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 32'd0);
        m0_req = 1; m0_we = 1; m0_addr = 12'h010; m0_wdata = 32'hDEADBEEF; m0_be = 4'hF;
        @(negedge clk);
        check_output("sw_n_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        check_output("sw_n1_write", 32'(mem_write), 32'd1);
        check_output("sw_n1_addr", 32'(mem_a), 32'h010);
        @(negedge clk);
        check_output("sw_n2_m0_done", 32'(m0_done), 32'd1);
        check_output("sw_n2_m1_done", 32'(m1_done), 32'd0);
        check_output("sw_n2_write", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        m0_req = 0;
        @(negedge clk);
        check_output("sw_n3_m0_done", 32'(m0_done), 32'd0);

        $display("[TB] read-back on port 1");
        @(posedge clk);
        #1;
        expect_txn(1, 0, 12'h010, 32'd0, 4'hF, 32'hDEADBEEF);
        apply_stimulus(1, 0, 12'h010, 32'd0, 4'hF, 0);
        repeat (4) @(posedge clk);
        #1;
        check_output("rb_hold", m1_rdata, 32'hDEADBEEF);

        $display("[TB] partial byte-enable write and read-back");
        expect_txn(0, 1, 12'h020, 32'h12345678, 4'h3, 32'd0);
        apply_stimulus(0, 1, 12'h020, 32'h12345678, 4'h3, 0);
        expect_txn(0, 0, 12'h020, 32'd0, 4'hF, 32'h00005678);
        apply_stimulus(0, 0, 12'h020, 32'd0, 4'hF, 0);

        $display("[TB] reset asserted during BUSY");
        m0_req = 1; m0_we = 1; m0_addr = 12'h030; m0_wdata = 32'h00000055; m0_be = 4'hF;
        @(posedge clk);
        #2;
        check_output("rb_busy_write", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check_output("rb_write_drop", 32'(mem_write), 32'd0);
        check_output("rb_outputs_zero", {16'(mem_a), 12'(mem_wdata != 0), mem_be}, 32'd0);
        check_output("rb_rdata_zero", m0_rdata | m1_rdata, 32'd0);
        m0_req = 0;
        @(posedge clk);
        #1;
        check_output("rb_no_write", 32'(mem_write), 32'd0);
        check_output("rb_no_done", {30'd0, m0_done, m1_done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        expect_txn(0, 0, 12'h030, 32'd0, 4'hF, 32'h0BADF00D);
        apply_stimulus(0, 0, 12'h030, 32'd0, 4'hF, 0);
        expect_txn(1, 0, 12'h010, 32'd0, 4'hF, 32'hDEADBEEF);
        apply_stimulus(1, 0, 12'h010, 32'd0, 4'hF, 0);

        $display("[TB] contention from reset");
        reset = 1'b0;
        m0_req = 1; m0_we = 1; m0_addr = 12'h100; m0_wdata = 32'hA0A0A0A0; m0_be = 4'hF;
        m1_req = 1; m1_we = 1; m1_addr = 12'h101; m1_wdata = 32'hB1B1B1B1; m1_be = 4'hF;
        expect_txn(0, 1, 12'h100, 32'hA0A0A0A0, 4'hF, 32'd0);
        expect_txn(1, 1, 12'h101, 32'hB1B1B1B1, 4'hF, 32'd0);
        expect_txn(0, 0, 12'h101, 32'd0, 4'hF, 32'hB1B1B1B1);
        expect_txn(1, 0, 12'h100, 32'd0, 4'hF, 32'hA0A0A0A0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        done_cycles.delete();
        reset = 1'b1;
        fork
            begin
                apply_stimulus(0, 1, 12'h100, 32'hA0A0A0A0, 4'hF, 0);
                apply_stimulus(0, 0, 12'h101, 32'd0, 4'hF, 0);
            end
            begin
                apply_stimulus(1, 1, 12'h101, 32'hB1B1B1B1, 4'hF, 0);
                apply_stimulus(1, 0, 12'h100, 32'd0, 4'hF, 0);
            end
        join
        check_output("ct_done_count", 32'(done_cycles.size()), 32'd4);
        if (done_cycles.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check_output("ct_done_spacing", 32'(done_cycles[i] - done_cycles[i-1]), 32'd3);
            end
        end

`ifdef DM_ARB_LOCK_EN
        $display("[TB] port-1 lock burst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expect_txn(0, 1, 12'h200, 32'h00000200, 4'hF, 32'd0);
        expect_txn(1, 1, 12'h201, 32'h00000201, 4'hF, 32'd0);
        expect_txn(1, 1, 12'h202, 32'h00000202, 4'hF, 32'd0);
        expect_txn(1, 1, 12'h203, 32'h00000203, 4'hF, 32'd0);
        expect_txn(0, 1, 12'h204, 32'h00000204, 4'hF, 32'd0);
        expect_txn(1, 1, 12'h205, 32'h00000205, 4'hF, 32'd0);
        fork
            begin
                apply_stimulus(0, 1, 12'h200, 32'h00000200, 4'hF, 0);
                apply_stimulus(0, 1, 12'h204, 32'h00000204, 4'hF, 0);
            end
            begin
                apply_stimulus(1, 1, 12'h201, 32'h00000201, 4'hF, 1);
                apply_stimulus(1, 1, 12'h202, 32'h00000202, 4'hF, 1);
                apply_stimulus(1, 1, 12'h203, 32'h00000203, 4'hF, 1);
                apply_stimulus(1, 1, 12'h205, 32'h00000205, 4'hF, 0);
            end
        join
`endif

        repeat (3) @(posedge clk);
        #1;
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
